// File: rtl/pwm_deadtime_gen.sv
// Purpose : complementary high/low gate drive with programmable dead time from a single PWM input.
// Latency : a pwm_in edge sampled at edge E drops the active output after E; the opposite output rises after E+N.
// Backpr. : none; free-running datapath, pwm_in and dt_cfg/dt_load are sampled every clock.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   en                enable; low forces OFF with both outputs low
//   pwm_in            upstream PWM, same clock domain, already registered
//   dt_cfg, dt_load   dead-time value (clk cycles) and its shadow-register write strobe
//   out_hi, out_lo    registered gate drives, never high together
//   short_pulse       one-cycle flag when pwm_in reverses inside a dead-time interval
module pwm_deadtime_gen #(
  parameter int              DT_W       = 8,
  parameter logic [DT_W-1:0] DT_DEFAULT = DT_W'(4)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_cfg,
  input  logic            dt_load,
  output logic            out_hi,
  output logic            out_lo,
  output logic            short_pulse
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    DT_RISE = 3'd1,
    HI_ON   = 3'd2,
    DT_FALL = 3'd3,
    LO_ON   = 3'd4
  } state_t;

  localparam logic [DT_W-1:0] ONE = DT_W'(1);

  state_t          state;
  logic [DT_W-1:0] cnt;
  logic [DT_W-1:0] dt_shadow;
  logic [DT_W-1:0] dt_n;

  // A zero dead time still yields one both-low cycle so the outputs can never overlap.
  // Reads the registered shadow, so a dt_load on the same edge as a DT entry is seen one entry later.
  assign dt_n = (dt_shadow == '0) ? ONE : dt_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      cnt         <= '0;
      dt_shadow   <= DT_DEFAULT;
      out_hi      <= 1'b0;
      out_lo      <= 1'b0;
      short_pulse <= 1'b0;
    end else begin
      if (dt_load) begin
        dt_shadow <= dt_cfg;
      end
      short_pulse <= 1'b0;

      if (!en) begin
        state  <= OFF;
        cnt    <= '0;
        out_hi <= 1'b0;
        out_lo <= 1'b0;
      end else begin
        case (state)
          OFF: begin
            cnt    <= dt_n;
            out_hi <= 1'b0;
            out_lo <= 1'b0;
            state  <= pwm_in ? DT_RISE : DT_FALL;
          end
          HI_ON: begin
            if (!pwm_in) begin
              state  <= DT_FALL;
              cnt    <= dt_n;
              out_hi <= 1'b0;
            end
          end
          LO_ON: begin
            if (pwm_in) begin
              state  <= DT_RISE;
              cnt    <= dt_n;
              out_lo <= 1'b0;
            end
          end
          DT_RISE: begin
            // Reversal wins over expiry: a pulse no longer than N never reaches the gate.
            if (!pwm_in) begin
              state       <= DT_FALL;
              cnt         <= dt_n;
              short_pulse <= 1'b1;
            end else if (cnt == ONE) begin
              state  <= HI_ON;
              out_hi <= 1'b1;
            end else if (cnt > ONE) begin
              cnt <= cnt - ONE;
            end
          end
          DT_FALL: begin
            if (pwm_in) begin
              state       <= DT_RISE;
              cnt         <= dt_n;
              short_pulse <= 1'b1;
            end else if (cnt == ONE) begin
              state  <= LO_ON;
              out_lo <= 1'b1;
            end else if (cnt > ONE) begin
              cnt <= cnt - ONE;
            end
          end
          default: begin
            state  <= OFF;
            cnt    <= '0;
            out_hi <= 1'b0;
            out_lo <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
